// File: rtl/dpram_fifo_ctrl_if.sv
// Valid/ready stream bundle: producer -> FIFO controller (s_*), controller -> consumer (m_*).
interface dpram_fifo_ctrl_if #(
    parameter int unsigned DW = 32
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    // Controller side: sinks the producer stream, sources the consumer stream.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    // Environment side: drives producer words and consumer acceptance.
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller around an external dual-port RAM (port A write, port B read).
// The RAM's read latency is hidden by a small output skid buffer; reads are only issued
// when the skid is guaranteed to have room for the returning word.
module dpram_fifo_ctrl #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 11,
    parameter int unsigned DEPTH   = 1280,
    parameter int unsigned N_DELAY = 1,
    localparam int unsigned LW     = $clog2(DEPTH + N_DELAY + 2)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    dpram_fifo_ctrl_if.slave strm_io,
    output logic [LW-1:0]    level_o,
    output logic             ram_ena_o,
    output logic             ram_wea_o,
    output logic [AW-1:0]    ram_addra_o,
    output logic [DW-1:0]    ram_dia_o,
    output logic             ram_enb_o,
    output logic [AW-1:0]    ram_addrb_o,
    input  logic [DW-1:0]    ram_dob_i
);
    localparam int unsigned SKID = N_DELAY + 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned PW   = $clog2(N_DELAY + 1);
    localparam int unsigned SCW  = $clog2(SKID + 1);
    localparam int unsigned SIW  = $clog2(SKID);
    localparam int unsigned CRW  = SCW + 1;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      mem_cnt_q, mem_cnt_d;
    logic [N_DELAY-1:0] vld_pipe_q, vld_pipe_d;
    logic [DW-1:0]      skid_mem_q [SKID];
    logic [SIW-1:0]     skid_wr_q, skid_wr_d;
    logic [SIW-1:0]     skid_rd_q, skid_rd_d;
    logic [SCW-1:0]     skid_cnt_q, skid_cnt_d;
    logic [PW-1:0]      inflight;
    logic               push, pop, issue, capture;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [SIW-1:0] skid_inc(input logic [SIW-1:0] p);
        return (p == SIW'(SKID - 1)) ? '0 : p + SIW'(1);
    endfunction

    // Handshakes; s_ready looks only at mem_cnt so a pop never combinationally opens the input.
    assign strm_io.s_ready = !rst_i && (mem_cnt_q != CW'(DEPTH));
    assign strm_io.m_valid = (skid_cnt_q != '0);
    assign strm_io.m_data  = skid_mem_q[skid_rd_q];

    // A flush drops the same-cycle push and does not count the same-cycle pop.
    assign push     = strm_io.s_valid && strm_io.s_ready && !flush_i;
    assign pop      = strm_io.m_valid && strm_io.m_ready && !flush_i;
    assign inflight = PW'($countones(vld_pipe_q));
    assign capture  = vld_pipe_q[N_DELAY-1] && !flush_i && !rst_i;

    // Credit rule: words in flight plus words held, minus the one leaving now, must leave a slot.
    assign issue = (mem_cnt_q != '0) &&
                   ((CRW'(inflight) + CRW'(skid_cnt_q)) < (CRW'(SKID) + CRW'(pop)));

    assign ram_ena_o   = push;
    assign ram_wea_o   = push;
    assign ram_addra_o = wr_ptr_q;
    assign ram_dia_o   = strm_io.s_data;
    // Port B stays enabled so a multi-stage RAM output chain keeps advancing.
    assign ram_enb_o   = !rst_i;
    assign ram_addrb_o = rd_ptr_q;

    assign level_o = LW'(mem_cnt_q) + LW'(inflight) + LW'(skid_cnt_q);

    // Next-state for pointers, counters, read-tag pipe and skid indices.
    always_comb begin
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_cnt_d     = mem_cnt_q + CW'(push) - CW'(issue);
        vld_pipe_d    = '0;
        vld_pipe_d[0] = issue;
        for (int i = 1; i < int'(N_DELAY); i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
        skid_wr_d  = capture ? skid_inc(skid_wr_q) : skid_wr_q;
        skid_rd_d  = pop ? skid_inc(skid_rd_q) : skid_rd_q;
        skid_cnt_d = skid_cnt_q + SCW'(capture) - SCW'(pop);
    end

    // Control state; reset and flush clear identically, RAM contents are left alone.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            vld_pipe_q <= '0;
            skid_wr_q  <= '0;
            skid_rd_q  <= '0;
            skid_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            vld_pipe_q <= vld_pipe_d;
            skid_wr_q  <= skid_wr_d;
            skid_rd_q  <= skid_rd_d;
            skid_cnt_q <= skid_cnt_d;
        end
    end

    // Skid storage: tagged RAM output is captured when its read tag leaves the pipe.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            skid_mem_q[skid_wr_q] <= ram_dob_i;
        end
    end

    // The credit rule must make a capture into a full, non-draining skid impossible.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(capture && (skid_cnt_q == SCW'(SKID)) && !pop));
        end
    end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench: two controllers (N_DELAY=1 and N_DELAY=3) share one stimulus stream,
// each attached to its own behavioural RAM and scoreboard.
module tb_dpram_fifo_ctrl;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 11;
    localparam int unsigned DEPTH = 1280;
    localparam int unsigned LW1   = $clog2(DEPTH + 1 + 2);
    localparam int unsigned LW3   = $clog2(DEPTH + 3 + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;

    int n_chk = 0;
    int n_fail = 0;
    int acc1 = 0, acc3 = 0, pop1c = 0, pop3c = 0;
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q3[$];

    always #5 clk = ~clk;

    dpram_fifo_ctrl_if #(.DW(DW)) if1 ();
    dpram_fifo_ctrl_if #(.DW(DW)) if3 ();
    assign if1.s_valid = s_valid;
    assign if1.s_data  = s_data;
    assign if1.m_ready = m_ready;
    assign if3.s_valid = s_valid;
    assign if3.s_data  = s_data;
    assign if3.m_ready = m_ready;

    logic [LW1-1:0] level1;
    logic [LW3-1:0] level3;
    logic           ena1, wea1, enb1, ena3, wea3, enb3;
    logic [AW-1:0]  addra1, addrb1, addra3, addrb3;
    logic [DW-1:0]  dia1, dob1, dia3, dob3;

    dpram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .N_DELAY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .strm_io(if1), .level_o(level1),
        .ram_ena_o(ena1), .ram_wea_o(wea1), .ram_addra_o(addra1), .ram_dia_o(dia1),
        .ram_enb_o(enb1), .ram_addrb_o(addrb1), .ram_dob_i(dob1)
    );

    dpram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .N_DELAY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .strm_io(if3), .level_o(level3),
        .ram_ena_o(ena3), .ram_wea_o(wea3), .ram_addra_o(addra3), .ram_dia_o(dia3),
        .ram_enb_o(enb3), .ram_addrb_o(addrb3), .ram_dob_i(dob3)
    );

    // Behavioural RAMs with 1-cycle and 3-cycle registered read paths.
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem3 [DEPTH];
    logic [DW-1:0] rp1;
    logic [DW-1:0] rp3 [3];

    always_ff @(posedge clk) begin
        if (ena1 && wea1) mem1[addra1] <= dia1;
        if (enb1) rp1 <= mem1[addrb1];
        if (ena3 && wea3) mem3[addra3] <= dia3;
        if (enb3) begin
            rp3[0] <= mem3[addrb3];
            rp3[1] <= rp3[0];
            rp3[2] <= rp3[1];
        end
    end
    assign dob1 = rp1;
    assign dob3 = rp3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: level must equal accepted-minus-delivered; delivered data must be FIFO order.
    always @(negedge clk) begin
        if (!rst) begin
            chk("level1", 64'(level1), 64'(q1.size()));
            chk("level3", 64'(level3), 64'(q3.size()));
            if (flush) begin
                q1.delete();
                q3.delete();
            end else begin
                if (if1.m_valid && m_ready) begin
                    pop1c++;
                    if (q1.size() == 0) chk("pop1_nonempty", 64'(q1.size()), 64'(1));
                    else chk("data1", 64'(if1.m_data), 64'(q1.pop_front()));
                end
                if (if3.m_valid && m_ready) begin
                    pop3c++;
                    if (q3.size() == 0) chk("pop3_nonempty", 64'(q3.size()), 64'(1));
                    else chk("data3", 64'(if3.m_data), 64'(q3.pop_front()));
                end
                if (s_valid && if1.s_ready) begin
                    acc1++;
                    q1.push_back(s_data);
                end
                if (s_valid && if3.s_ready) begin
                    acc3++;
                    q3.push_back(s_data);
                end
            end
        end
    end

    // Single push into an empty FIFO; m_valid must rise at cycle N_DELAY+2.
    task automatic lat_probe(input string tag, input logic [DW-1:0] word);
        int f1, f3, p1, p3;
        f1 = -1;
        f3 = -1;
        p1 = pop1c;
        p3 = pop3c;
        s_valid = 1'b1;
        s_data  = word;
        m_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            s_valid = 1'b0;
            if (if1.m_valid && f1 < 0) begin
                f1 = c;
                chk({tag, "_data1"}, 64'(if1.m_data), 64'(word));
            end
            if (if3.m_valid && f3 < 0) begin
                f3 = c;
                chk({tag, "_data3"}, 64'(if3.m_data), 64'(word));
            end
        end
        chk({tag, "_cycle1"}, 64'(f1), 64'(3));
        chk({tag, "_cycle3"}, 64'(f3), 64'(5));
        chk({tag, "_npop1"}, 64'(pop1c - p1), 64'(1));
        chk({tag, "_npop3"}, 64'(pop3c - p3), 64'(1));
        chk({tag, "_lvl1"}, 64'(level1), 64'(0));
        chk({tag, "_lvl3"}, 64'(level3), 64'(0));
    endtask

    initial begin
        int b1, b3, g1, g3, cyc;
        bit seen1, seen3;

        // Reset: s_ready low and RAM port B idle while rst is held.
        tick();
        chk("rst_s_ready1", 64'(if1.s_ready), 64'(0));
        chk("rst_s_ready3", 64'(if3.s_ready), 64'(0));
        chk("rst_enb1", 64'(enb1), 64'(0));
        chk("rst_m_valid1", 64'(if1.m_valid), 64'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_s_ready1", 64'(if1.s_ready), 64'(1));
        chk("post_rst_s_ready3", 64'(if3.s_ready), 64'(1));
        chk("post_rst_enb1", 64'(enb1), 64'(1));
        chk("post_rst_ena1", 64'(ena1), 64'(0));
        chk("post_rst_lvl1", 64'(level1), 64'(0));
        chk("post_rst_m_valid3", 64'(if3.m_valid), 64'(0));

        lat_probe("lat", 32'hA5A5_0001);

        // Capacity with the consumer stalled: DEPTH+SKID words accepted.
        b1 = acc1;
        b3 = acc3;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 1300; i++) begin
            s_data = DW'(i);
            tick();
        end
        chk("cap_acc1", 64'(acc1 - b1), 64'(1282));
        chk("cap_acc3", 64'(acc3 - b3), 64'(1284));
        chk("cap_s_ready1", 64'(if1.s_ready), 64'(0));
        chk("cap_s_ready3", 64'(if3.s_ready), 64'(0));
        chk("cap_lvl1", 64'(level1), 64'(1282));
        chk("cap_lvl3", 64'(level3), 64'(1284));
        chk("cap_head1", 64'(if1.m_data), 64'(0));
        chk("cap_head3", 64'(if3.m_data), 64'(0));
        s_valid = 1'b0;
        m_ready = 1'b1;
        b1 = pop1c;
        b3 = pop3c;
        for (int i = 0; i < 1300; i++) tick();
        chk("drain_npop1", 64'(pop1c - b1), 64'(1282));
        chk("drain_npop3", 64'(pop3c - b3), 64'(1284));
        chk("drain_m_valid1", 64'(if1.m_valid), 64'(0));
        chk("drain_m_valid3", 64'(if3.m_valid), 64'(0));

        // Full-throughput streaming across several pointer wraps; no output bubbles.
        b1 = acc1;
        b3 = acc3;
        g1 = 0;
        g3 = 0;
        seen1 = 1'b0;
        seen3 = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            s_data = 32'h1000_0000 + DW'(i);
            tick();
            if (if1.m_valid) seen1 = 1'b1;
            else if (seen1) g1++;
            if (if3.m_valid) seen3 = 1'b1;
            else if (seen3) g3++;
        end
        s_valid = 1'b0;
        chk("stream_acc1", 64'(acc1 - b1), 64'(5000));
        chk("stream_acc3", 64'(acc3 - b3), 64'(5000));
        chk("stream_gaps1", 64'(g1), 64'(0));
        chk("stream_gaps3", 64'(g3), 64'(0));
        for (int i = 0; i < 20; i++) tick();
        chk("stream_end_lvl1", 64'(level1), 64'(0));
        chk("stream_end_lvl3", 64'(level3), 64'(0));

        // Random backpressure on both sides.
        b1 = acc1;
        cyc = 0;
        while ((acc1 - b1) < 20000 && cyc < 40000) begin
            s_valid = ($urandom_range(99) >= 30);
            m_ready = ($urandom_range(99) >= 30);
            s_data  = $urandom;
            tick();
            cyc++;
        end
        chk("rand_reached_20000", 64'((acc1 - b1) >= 20000), 64'(1));
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 1400; i++) tick();
        chk("rand_q1_empty", 64'(q1.size()), 64'(0));
        chk("rand_q3_empty", 64'(q3.size()), 64'(0));
        chk("rand_m_valid1", 64'(if1.m_valid), 64'(0));

        // Flush with a backlog and reads in flight, plus a same-cycle push that must vanish.
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = 32'd2000 + DW'(i);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hBAD0_BAD0;
        m_ready = 1'b0;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("flush_lvl1", 64'(level1), 64'(0));
        chk("flush_lvl3", 64'(level3), 64'(0));
        chk("flush_m_valid1", 64'(if1.m_valid), 64'(0));
        chk("flush_m_valid3", 64'(if3.m_valid), 64'(0));
        chk("flush_s_ready1", 64'(if1.s_ready), 64'(1));
        tick();
        lat_probe("post_flush", 32'h0000_DEAD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
